// File: rtl/if_id_hazard_stage.sv
// IF/ID pipeline register with load-use stall and taken-branch squash.
// Drives PCWrite to fetch and ControlBubble to decode.
module if_id_hazard_stage #(
  parameter int DATA_W           = 32,
  parameter int REG_W            = 5,
  parameter int LOAD_USE_BUBBLES = 1,
  parameter int FLUSH_CYCLES     = 1
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic [DATA_W-1:0] InstructionIn,
  input  logic [DATA_W-1:0] PCAddResultIn,
  input  logic              FetchValid,
  input  logic              IDEX_MemRead,
  input  logic [REG_W-1:0]  IDEX_RTRegdest,
  input  logic              BranchTaken,
  output logic [DATA_W-1:0] InstructionOut,
  output logic [DATA_W-1:0] PCAddResultOut,
  output logic              ValidOut,
  output logic              PCWrite,
  output logic              ControlBubble,
  output logic [1:0]        StateOut
);

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    STALL = 2'd1,
    FLUSH = 2'd2
  } state_e;

  localparam logic [1:0] LU_CNT = 2'(LOAD_USE_BUBBLES - 1);
  localparam logic [1:0] FL_CNT = 2'(FLUSH_CYCLES - 1);

  state_e            state_q, state_d;
  logic [1:0]        cnt_q, cnt_d;
  logic [DATA_W-1:0] instr_q, instr_d;
  logic [DATA_W-1:0] pc_q, pc_d;
  logic              valid_q, valid_d;
  logic              hazard;

  // Register $0 is hard-wired zero, so it never creates a dependence.
  assign hazard = valid_q && IDEX_MemRead
               && (IDEX_RTRegdest != '0)
               && ((IDEX_RTRegdest == instr_q[25:21])
                || (IDEX_RTRegdest == instr_q[20:16]));

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    instr_d       = instr_q;
    pc_d          = pc_q;
    valid_d       = valid_q;
    PCWrite       = 1'b1;
    ControlBubble = ~valid_q;
    if (!Reset) begin
      PCWrite       = 1'b0;
      ControlBubble = 1'b1;
      state_d       = RUN;
      cnt_d         = '0;
      instr_d       = '0;
      pc_d          = '0;
      valid_d       = 1'b0;
    end else if (BranchTaken) begin
      instr_d       = '0;
      valid_d       = 1'b0;
      ControlBubble = 1'b1;
      if (FLUSH_CYCLES > 1) begin
        state_d = FLUSH;
        cnt_d   = FL_CNT;
      end else begin
        state_d = RUN;
        cnt_d   = '0;
      end
    end else begin
      case (state_q)
        RUN: begin
          if (hazard) begin
            PCWrite       = 1'b0;
            ControlBubble = 1'b1;
            if (LOAD_USE_BUBBLES > 1) begin
              state_d = STALL;
              cnt_d   = LU_CNT;
            end
          end else begin
            instr_d = InstructionIn;
            pc_d    = PCAddResultIn;
            valid_d = FetchValid;
          end
        end
        STALL: begin
          PCWrite       = 1'b0;
          ControlBubble = 1'b1;
          if (cnt_q <= 2'd1) begin
            state_d = RUN;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q - 2'd1;
          end
        end
        FLUSH: begin
          instr_d       = '0;
          valid_d       = 1'b0;
          ControlBubble = 1'b1;
          if (cnt_q <= 2'd1) begin
            state_d = RUN;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q - 2'd1;
          end
        end
        default: begin
          state_d = RUN;
          cnt_d   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      state_q <= RUN;
      cnt_q   <= '0;
      instr_q <= '0;
      pc_q    <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      instr_q <= instr_d;
      pc_q    <= pc_d;
      valid_q <= valid_d;
    end
  end

  assign InstructionOut = instr_q;
  assign PCAddResultOut = pc_q;
  assign ValidOut       = valid_q;
  assign StateOut       = state_q;

endmodule

// File: tb/tb_if_id_hazard_stage.sv
// Bench for if_id_hazard_stage: three parameterisations against a
// remaining-cycles reference model, directed plan then random traffic.
module tb_if_id_hazard_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] ins, pca;
  logic        fv, mr, br;
  logic [4:0]  rt;

  logic [31:0] io [3];
  logic [31:0] po [3];
  logic        vo [3];
  logic        pw [3];
  logic        cb [3];
  logic [1:0]  so [3];

  int m_lub [3] = '{1, 2, 3};
  int m_fc  [3] = '{2, 1, 3};

  logic [31:0] m_ins [3];
  logic [31:0] m_pc  [3];
  logic        m_val [3];
  int          m_st  [3];
  int          m_fl  [3];

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  if_id_hazard_stage #(.LOAD_USE_BUBBLES(1), .FLUSH_CYCLES(2)) u0 (
    .Clk(clk), .Reset(rst_n), .InstructionIn(ins), .PCAddResultIn(pca),
    .FetchValid(fv), .IDEX_MemRead(mr), .IDEX_RTRegdest(rt),
    .BranchTaken(br), .InstructionOut(io[0]), .PCAddResultOut(po[0]),
    .ValidOut(vo[0]), .PCWrite(pw[0]), .ControlBubble(cb[0]),
    .StateOut(so[0]));

  if_id_hazard_stage #(.LOAD_USE_BUBBLES(2), .FLUSH_CYCLES(1)) u1 (
    .Clk(clk), .Reset(rst_n), .InstructionIn(ins), .PCAddResultIn(pca),
    .FetchValid(fv), .IDEX_MemRead(mr), .IDEX_RTRegdest(rt),
    .BranchTaken(br), .InstructionOut(io[1]), .PCAddResultOut(po[1]),
    .ValidOut(vo[1]), .PCWrite(pw[1]), .ControlBubble(cb[1]),
    .StateOut(so[1]));

  if_id_hazard_stage #(.LOAD_USE_BUBBLES(3), .FLUSH_CYCLES(3)) u2 (
    .Clk(clk), .Reset(rst_n), .InstructionIn(ins), .PCAddResultIn(pca),
    .FetchValid(fv), .IDEX_MemRead(mr), .IDEX_RTRegdest(rt),
    .BranchTaken(br), .InstructionOut(io[2]), .PCAddResultOut(po[2]),
    .ValidOut(vo[2]), .PCWrite(pw[2]), .ControlBubble(cb[2]),
    .StateOut(so[2]));

  function automatic logic hz(int k);
    return m_val[k] && mr && (rt != 5'd0)
        && ((rt == m_ins[k][25:21]) || (rt == m_ins[k][20:16]));
  endfunction

  task automatic chk(string tag, int k, logic [31:0] got, logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s dut%0d: got %h expected %h", tag, k, got, exp);
    end
  endtask

  task automatic model_init();
    for (int k = 0; k < 3; k++) begin
      m_ins[k] = '0; m_pc[k] = '0; m_val[k] = 1'b0;
      m_st[k] = 0; m_fl[k] = 0;
    end
  endtask

  task automatic cycle();
    logic ew, eb;
    logic [1:0] es;
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      es = (m_fl[k] > 0) ? 2'd2 : (m_st[k] > 0) ? 2'd1 : 2'd0;
      if (!rst_n)         begin ew = 1'b0; eb = 1'b1; end
      else if (br)        begin ew = 1'b1; eb = 1'b1; end
      else if (m_fl[k]>0) begin ew = 1'b1; eb = 1'b1; end
      else if (m_st[k]>0) begin ew = 1'b0; eb = 1'b1; end
      else if (hz(k))     begin ew = 1'b0; eb = 1'b1; end
      else                begin ew = 1'b1; eb = ~m_val[k]; end
      chk("instr", k, io[k], m_ins[k]);
      chk("pc4", k, po[k], m_pc[k]);
      chk("valid", k, 32'(vo[k]), 32'(m_val[k]));
      chk("pcwrite", k, 32'(pw[k]), 32'(ew));
      chk("bubble", k, 32'(cb[k]), 32'(eb));
      chk("state", k, 32'(so[k]), 32'(es));
    end
    for (int k = 0; k < 3; k++) begin
      if (!rst_n) begin
        m_ins[k] = '0; m_pc[k] = '0; m_val[k] = 1'b0;
        m_st[k] = 0; m_fl[k] = 0;
      end else if (br) begin
        m_ins[k] = '0; m_val[k] = 1'b0;
        m_st[k] = 0; m_fl[k] = m_fc[k] - 1;
      end else if (m_fl[k] > 0) begin
        m_ins[k] = '0; m_val[k] = 1'b0;
        m_fl[k]--;
      end else if (m_st[k] > 0) begin
        m_st[k]--;
      end else if (hz(k)) begin
        m_st[k] = m_lub[k] - 1;
      end else begin
        m_ins[k] = ins; m_pc[k] = pca; m_val[k] = fv;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drv(logic r, logic f, logic [31:0] i, logic [31:0] p,
                     logic m, logic [4:0] d, logic b);
    rst_n = r; fv = f; ins = i; pca = p; mr = m; rt = d; br = b;
    cycle();
  endtask

  initial begin
    rst_n = 1'b0; fv = 1'b1; ins = 32'h8C220004; pca = '0;
    mr = 1'b0; rt = '0; br = 1'b0;
    @(posedge clk);
    #1;
    model_init();
    drv(0, 1, 32'h8C220004, 32'h0, 0, 0, 0);
    drv(0, 1, 32'h8C220004, 32'h0, 0, 0, 0);
    drv(1, 1, 32'h00221820, 32'h4, 0, 0, 0);
    drv(1, 1, 32'h00621820, 32'h8, 0, 0, 0);
    drv(1, 1, 32'h00000000, 32'hC, 1, 3, 0);
    drv(1, 1, 32'h00000000, 32'hC, 1, 3, 0);
    drv(1, 1, 32'h00000000, 32'hC, 0, 3, 0);
    drv(1, 1, 32'h00000000, 32'hC, 0, 3, 0);
    drv(1, 1, 32'h00621820, 32'h10, 0, 0, 0);
    drv(1, 1, 32'h00A21820, 32'h14, 1, 0, 0);
    drv(1, 1, 32'h00A21820, 32'h14, 1, 0, 0);
    drv(1, 1, 32'h11111111, 32'h18, 0, 0, 1);
    drv(1, 1, 32'h22222222, 32'h1C, 0, 0, 0);
    drv(1, 1, 32'h33333333, 32'h20, 0, 0, 0);
    drv(1, 1, 32'h00621820, 32'h24, 0, 0, 0);
    drv(1, 1, 32'h44444444, 32'h28, 0, 0, 0);
    drv(1, 1, 32'h00621820, 32'h2C, 0, 0, 0);
    drv(1, 1, 32'h55555555, 32'h30, 1, 3, 1);
    drv(1, 1, 32'h66666666, 32'h34, 1, 3, 0);
    drv(0, 1, 32'h77777777, 32'h38, 0, 0, 0);
    drv(1, 1, 32'h88888888, 32'h3C, 0, 0, 0);
    repeat (400) begin
      logic [31:0] ri;
      ri = $urandom;
      ri[25:21] = 5'($urandom_range(0, 3));
      ri[20:16] = 5'($urandom_range(0, 3));
      drv(($urandom_range(0, 39) != 0), 1'($urandom),
          ri, $urandom, ($urandom_range(0, 2) != 0),
          5'($urandom_range(0, 3)), ($urandom_range(0, 9) == 0));
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/if_id_hazard_stage.md
Name: if_id_hazard_stage

Overview:
- IF/ID pipeline register with built-in load-use hazard stall and taken-branch squash control.
- Sits directly upstream of the ID/EX register: it holds the fetched instruction and PC+4 for decode, and drives PCWrite to the PC.
- It also drives ControlBubble, which the decode stage uses to zero the control word sent into ID/EX.

Parameters:
- DATA_W, 32, instruction/PC width.
- REG_W, 5, register specifier width.
- LOAD_USE_BUBBLES, 1, bubbles inserted per load-use hazard (1..3).
- FLUSH_CYCLES, 1, fetch slots squashed per taken branch (1..3).

Ports:
- Clk  in  1  pipeline clock; all state updates on posedge.
- Reset  in  1  synchronous, active-low reset.
- InstructionIn  in  DATA_W  fetched instruction.
- PCAddResultIn  in  DATA_W  PC+4 from fetch.
- FetchValid  in  1  InstructionIn is valid this cycle.
- IDEX_MemRead  in  1  MemRead currently held in ID/EX.
- IDEX_RTRegdest  in  REG_W  rt destination currently held in ID/EX.
- BranchTaken  in  1  branch resolved taken this cycle.
- InstructionOut  out  DATA_W  registered instruction to decode.
- PCAddResultOut  out  DATA_W  registered PC+4 to decode.
- ValidOut  out  1  InstructionOut is a live instruction.
- PCWrite  out  1  PC may update this cycle.
- ControlBubble  out  1  decode must force all ID/EX control inputs to 0.
- StateOut  out  2  FSM state: RUN=0, STALL=1, FLUSH=2.

Behaviour:
- Reset low at posedge: the following take their reset values at that edge.
  - InstructionOut=0, PCAddResultOut=0, ValidOut=0.
  - State=RUN, internal counter=0.
- While Reset is low, combinational outputs are forced: PCWrite=0, ControlBubble=1.
- Reset low mid-STALL or mid-FLUSH abandons the sequence; the block is in RUN after the edge.
- Hazard (combinational) = all of the following:
  - ValidOut=1 and IDEX_MemRead=1 and IDEX_RTRegdest!=0;
  - IDEX_RTRegdest equals InstructionOut[25:21] or InstructionOut[20:16].
- Priority each cycle: Reset > BranchTaken > STALL/hazard > normal load.
- RUN, BranchTaken=1:
  - Next edge loads InstructionOut=0, ValidOut=0; PCAddResultOut keeps its value.
  - PCWrite=1, ControlBubble=1.
  - Go to FLUSH with counter=FLUSH_CYCLES-1 if FLUSH_CYCLES>1, else stay in RUN.
- RUN, Hazard=1 (no branch):
  - IF/ID holds all registered outputs; PCWrite=0, ControlBubble=1.
  - Go to STALL with counter=LOAD_USE_BUBBLES-1 if LOAD_USE_BUBBLES>1, else stay in RUN.
- RUN, otherwise:
  - Load InstructionOut<=InstructionIn, PCAddResultOut<=PCAddResultIn, ValidOut<=FetchValid.
  - PCWrite=1; ControlBubble=~ValidOut.
- STALL:
  - Hold IF/ID; PCWrite=0, ControlBubble=1; counter decrements each cycle.
  - Counter reaching 0 at an edge returns to RUN.
  - BranchTaken in STALL behaves exactly as BranchTaken in RUN (squash wins over hold).
- FLUSH:
  - Each edge loads InstructionOut=0, ValidOut=0; PCWrite=1, ControlBubble=1; counter decrements.
  - Counter 0 returns to RUN.
  - BranchTaken in FLUSH reloads counter=FLUSH_CYCLES-1.
- Hazard is ignored in FLUSH because ValidOut=0.
- Latency: one cycle from fetch to InstructionOut when not stalled.
- No combinational path from InstructionIn to any output.
- Register $0 never triggers a stall.

Test Plan:
- Reset low for 2 cycles with FetchValid=1 and InstructionIn=0x8C220004 -> InstructionOut=0, ValidOut=0, PCWrite=0, ControlBubble=1, StateOut=0.
- Reset high; stream InstructionIn=0x00221820, PCAddResultIn=0x4 -> InstructionOut=0x00221820, PCAddResultOut=0x4, ValidOut=1 one edge later; PCWrite=1, ControlBubble=0.
- InstructionOut=0x00621820 (rs=3), IDEX_MemRead=1, IDEX_RTRegdest=3, LOAD_USE_BUBBLES=1 -> exactly one cycle of PCWrite=0, ControlBubble=1 with InstructionOut held; after IDEX_MemRead drops, it loads normally.
- LOAD_USE_BUBBLES=2, same hazard -> StateOut=1 for 1 cycle, 2 total stall cycles; then IDEX_RTRegdest=0 with MemRead=1 -> no stall.
- FLUSH_CYCLES=2, BranchTaken pulse for 1 cycle with valid fetches -> ValidOut=0 and InstructionOut=0 for 2 edges, StateOut=2 for 1 cycle, PCWrite=1 throughout.
- BranchTaken asserted in the same cycle as a hazard, then Reset low during FLUSH -> squash wins over hold (ValidOut=0, PCWrite=1); Reset returns StateOut=0 and ValidOut=0 at the next edge.
